// File: rtl/std_fp_smult_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated fixed-point multiplier.
package std_fp_smult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int LATENCY  = 3;
    localparam int SAT_BITS = 128;

    function automatic logic [SAT_BITS-1:0] fp_sat_max(input int width);
        return (SAT_BITS'(1) << (width - 1)) - SAT_BITS'(1);
    endfunction

    function automatic logic [SAT_BITS-1:0] fp_sat_min(input int width);
        return SAT_BITS'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/std_fp_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit,
// rotate the index back.
module std_fp_rr_pick #(
    parameter int NREQ = 4,
    localparam int PW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    localparam logic [PW:0] NREQ_V = (PW+1)'(NREQ);

    logic [NREQ-1:0] eff;
    logic [NREQ-1:0] rot;
    logic [PW-1:0]   offset;
    logic [PW:0]     sum;

    always_comb begin
        eff    = req & ~mask;
        rot    = NREQ'({eff, eff} >> ptr);
        any    = |rot;
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) offset = PW'(i);
        end
        // Rotating back needs a modulo for non power-of-two NREQ.
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= NREQ_V) sum = sum - NREQ_V;
        grant_idx = sum[PW-1:0];
        grant     = any ? (NREQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/std_fp_smult_arb.sv
// One shared signed fixed-point multiplier arbitrated round-robin among NREQ requesters.
// Define STD_FP_SMULT_ARB_SAT_EN to saturate on integer overflow instead of wrapping.
module std_fp_smult_arb
    import std_fp_smult_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int NREQ       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         go,
    input  logic [NREQ*WIDTH-1:0]   left,
    input  logic [NREQ*WIDTH-1:0]   right,
    output logic [WIDTH-1:0]        out,
    output logic [NREQ-1:0]         done,
    output logic                    busy
);

    localparam int PW = $clog2(NREQ);

    if (FRAC_WIDTH != WIDTH - INT_WIDTH) begin : g_bad_frac
        $error("std_fp_smult_arb: FRAC_WIDTH must equal WIDTH-INT_WIDTH");
    end
    if (NREQ < 2) begin : g_bad_nreq
        $error("std_fp_smult_arb: NREQ must be at least 2");
    end

    state_t                  state, state_next;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           gidx;
    logic [NREQ-1:0]         gsel;
    logic [NREQ-1:0]         mask;
    logic [NREQ-1:0]         grant;
    logic [PW-1:0]           pick_idx;
    logic                    pick_any;
    logic signed [WIDTH-1:0] lop, rop;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        wrapped;
    logic                    prod_unused;

    std_fp_rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (go),
        .mask      (mask),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = '0;
        busy       = 1'b0;
        case (state)
            IDLE: if (pick_any) state_next = MUL;
            MUL: begin
                busy       = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                busy       = 1'b1;
                done       = go & gsel;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The just-served requester is masked for exactly one IDLE cycle so a go
    // that is still high right after its done does not start a second operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= '0;
            gidx <= '0;
            gsel <= '0;
            mask <= '0;
            lop  <= '0;
            rop  <= '0;
            prod <= '0;
        end else begin
            mask <= (state == OUT) ? gsel : '0;
            case (state)
                IDLE: if (pick_any) begin
                    gidx <= pick_idx;
                    gsel <= grant;
                    lop  <= left[pick_idx*WIDTH +: WIDTH];
                    rop  <= right[pick_idx*WIDTH +: WIDTH];
                end
                MUL: prod <= $signed({{WIDTH{lop[WIDTH-1]}}, lop}) *
                             $signed({{WIDTH{rop[WIDTH-1]}}, rop});
                OUT: ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                default: ;
            endcase
        end
    end

    assign wrapped     = prod[2*WIDTH-INT_WIDTH-1 -: WIDTH];
    assign prod_unused = ^{prod[2*WIDTH-1 -: INT_WIDTH], prod[WIDTH-INT_WIDTH-1:0]};

`ifdef STD_FP_SMULT_ARB_SAT_EN
    localparam logic [SAT_BITS-1:0] SAT_MAX_FULL = fp_sat_max(WIDTH);
    localparam logic [SAT_BITS-1:0] SAT_MIN_FULL = fp_sat_min(WIDTH);

    logic [INT_WIDTH:0] head;
    assign head = prod[2*WIDTH-1 -: INT_WIDTH+1];

    always_comb begin
        out = wrapped;
        if (head != '0 && head != '1) begin
            out = prod[2*WIDTH-1] ? SAT_MIN_FULL[WIDTH-1:0] : SAT_MAX_FULL[WIDTH-1:0];
        end
    end
`else
    assign out = wrapped;
`endif

endmodule

// File: tb/tb_std_fp_smult_arb.sv
// Scoreboard bench for std_fp_smult_arb in Q16.16 with four requesters.
module tb_std_fp_smult_arb;

    localparam int WIDTH      = 32;
    localparam int INT_WIDTH  = 16;
    localparam int FRAC_WIDTH = 16;
    localparam int NREQ       = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       go;
    logic [NREQ*WIDTH-1:0] left;
    logic [NREQ*WIDTH-1:0] right;
    logic [WIDTH-1:0]      out;
    logic [NREQ-1:0]       done;
    logic                  busy;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    std_fp_smult_arb #(
        .WIDTH      (WIDTH),
        .INT_WIDTH  (INT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .NREQ       (NREQ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .left  (left),
        .right (right),
        .out   (out),
        .done  (done),
        .busy  (busy)
    );

    // Reference: full signed product, keep Q16.16 window, optionally saturate.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        logic signed [2*WIDTH-1:0] p;
        logic [INT_WIDTH:0]        head;
        p    = $signed({{WIDTH{l[WIDTH-1]}}, l}) * $signed({{WIDTH{r[WIDTH-1]}}, r});
        head = p[2*WIDTH-1 -: INT_WIDTH+1];
`ifdef STD_FP_SMULT_ARB_SAT_EN
        if (head != '0 && head != '1) return p[2*WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return p[2*WIDTH-INT_WIDTH-1 -: WIDTH];
    endfunction

    task automatic issue(input int idx, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        exp_t e;
        left[idx*WIDTH +: WIDTH]  = l;
        right[idx*WIDTH +: WIDTH] = r;
        go[idx]                   = 1'b1;
        e.idx = idx;
        e.val = model(l, r);
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget, output logic [NREQ-1:0] d,
                             output logic [WIDTH-1:0] o, output int cyc);
        d   = '0;
        o   = '0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                d = done;
                o = out;
                break;
            end
        end
    endtask

    task automatic gap();
        go = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go    = '0;
        left  = '0;
        right = '0;
        repeat (2) @(negedge clk);
        n_compared++;
        if (out !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out: got %h expected %h", out, 32'h0);
        end
        n_compared++;
        if (done !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_done: got %b expected %b", done, 4'b0);
        end
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] o;
        int               cyc;
        exp_t             e;
        issue(1, 32'h0001_8000, 32'h0002_0000);
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b1 || done !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL single_cycle1: got busy=%b done=%b expected busy=1 done=0000", busy, done);
        end
        wait_done(6, d, o, cyc);
        e = sb.pop_front();
        n_compared++;
        if (d !== 4'b0010 || cyc !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL single_done: got %b after %0d extra cycles expected 0010 after 1", d, cyc);
        end
        n_compared++;
        if (o !== 32'h0003_0000 || o !== e.val) begin
            n_mismatched++;
            $display("[TB] FAIL single_out: got %h expected %h", o, 32'h0003_0000);
        end
        n_compared++;
        if (busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_busy_cycle2: got %b expected 1", busy);
        end
        go = '0;
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b0 || out !== 32'h0003_0000) begin
            n_mismatched++;
            $display("[TB] FAIL single_hold: got busy=%b out=%h expected busy=0 out=00030000", busy, out);
        end
        gap();
    endtask

    task automatic test_signed();
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] o;
        int               cyc;
        exp_t             e;
        logic [WIDTH-1:0] want [2];
        want[0] = 32'hFFFD_0000;
        want[1] = 32'h0001_0000;
        issue(2, 32'hFFFE_8000, 32'h0002_0000);
        issue(3, 32'hFFFF_0000, 32'hFFFF_0000);
        for (int k = 0; k < 2; k++) begin
            wait_done(8, d, o, cyc);
            e = sb.pop_front();
            n_compared++;
            if (d !== (NREQ'(1) << e.idx) || o !== e.val || o !== want[k]) begin
                n_mismatched++;
                $display("[TB] FAIL signed_%0d: got done=%b out=%h expected done=%b out=%h",
                         k, d, o, NREQ'(1) << e.idx, want[k]);
            end
            go[e.idx] = 1'b0;
        end
        gap();
    endtask

    task automatic test_overflow();
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] o;
        int               cyc;
        exp_t             e;
        logic [WIDTH-1:0] want [2];
`ifdef STD_FP_SMULT_ARB_SAT_EN
        want[0] = 32'h7FFF_FFFF;
        want[1] = 32'h8000_0000;
`else
        want[0] = 32'h3880_0000;
        want[1] = 32'hC780_0000;
`endif
        issue(0, 32'h00C8_0000, 32'h0190_0000);
        wait_done(8, d, o, cyc);
        e = sb.pop_front();
        n_compared++;
        if (d !== 4'b0001 || o !== e.val || o !== want[0]) begin
            n_mismatched++;
            $display("[TB] FAIL overflow_pos: got done=%b out=%h expected done=0001 out=%h", d, o, want[0]);
        end
        gap();
        issue(0, 32'hFF38_0000, 32'h0190_0000);
        wait_done(8, d, o, cyc);
        e = sb.pop_front();
        n_compared++;
        if (d !== 4'b0001 || o !== e.val || o !== want[1]) begin
            n_mismatched++;
            $display("[TB] FAIL overflow_neg: got done=%b out=%h expected done=0001 out=%h", d, o, want[1]);
        end
        gap();
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] o;
        int               cyc;
        exp_t             e;
        for (int k = 0; k < 6; k++) begin
            issue(int'($urandom_range(0, NREQ - 1)), WIDTH'($urandom), WIDTH'($urandom));
            wait_done(8, d, o, cyc);
            e = sb.pop_front();
            n_compared++;
            if (d !== (NREQ'(1) << e.idx) || o !== e.val || cyc !== 2) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_%0d: got done=%b out=%h lat=%0d expected done=%b out=%h lat=2",
                         k, d, o, cyc, NREQ'(1) << e.idx, e.val);
            end
            gap();
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] o;
        int               cyc;
        exp_t             e;
        int               want_lat [4];
        want_lat = '{2, 3, 2, 3};
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int round = 0; round < 2; round++) begin
            issue(0, 32'h0002_0000 + WIDTH'(round), 32'h0003_0000);
            issue(2, 32'h0004_0000, 32'hFFFF_8000 - WIDTH'(round));
            for (int k = 0; k < 2; k++) begin
                wait_done(8, d, o, cyc);
                e = sb.pop_front();
                n_compared++;
                if (d !== (NREQ'(1) << e.idx) || o !== e.val || cyc !== want_lat[round*2+k]) begin
                    n_mismatched++;
                    $display("[TB] FAIL contention_r%0d_%0d: got done=%b out=%h lat=%0d expected done=%b out=%h lat=%0d",
                             round, k, d, o, cyc, NREQ'(1) << e.idx, e.val, want_lat[round*2+k]);
                end
                go[e.idx] = 1'b0;
            end
            @(negedge clk);
        end
        gap();
    endtask

    task automatic test_reset_mid_op();
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] o;
        int               cyc;
        exp_t             e;
        left[1*WIDTH +: WIDTH]  = 32'h0005_0000;
        right[1*WIDTH +: WIDTH] = 32'h0005_0000;
        go[1] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        go    = '0;
        @(negedge clk);
        n_compared++;
        if (out !== '0 || done !== '0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_state: got out=%h done=%b busy=%b expected 0/0000/0", out, done, busy);
        end
        reset = 1'b0;
        issue(0, 32'h0001_0000, 32'h0007_0000);
        issue(3, 32'h0002_4000, 32'h0000_8000);
        for (int k = 0; k < 2; k++) begin
            wait_done(8, d, o, cyc);
            e = sb.pop_front();
            n_compared++;
            if (d !== (NREQ'(1) << e.idx) || o !== e.val) begin
                n_mismatched++;
                $display("[TB] FAIL midreset_order_%0d: got done=%b out=%h expected done=%b out=%h",
                         k, d, o, NREQ'(1) << e.idx, e.val);
            end
            go[e.idx] = 1'b0;
        end
        gap();
    endtask

    task automatic test_refire_held();
        logic [NREQ-1:0]  d;
        logic [WIDTH-1:0] o;
        int               cyc;
        exp_t             e;
        logic [NREQ-1:0]  seen;
        issue(1, 32'h0003_0000, 32'h0000_4000);
        wait_done(8, d, o, cyc);
        e = sb.pop_front();
        n_compared++;
        if (d !== 4'b0010 || o !== e.val) begin
            n_mismatched++;
            $display("[TB] FAIL refire_first: got done=%b out=%h expected done=0010 out=%h", d, o, e.val);
        end
        repeat (2) @(negedge clk);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL refire_busy: got %b expected 0", busy);
        end
        go   = '0;
        seen = '0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done;
        end
        n_compared++;
        if (seen !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL refire_done: got %b expected 0000", seen);
        end
        gap();
    endtask

    task automatic test_go_dropped();
        exp_t e;
        issue(2, 32'h0006_0000, 32'hFFFD_0000);
        @(negedge clk);
        go[2] = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        n_compared++;
        if (done !== '0 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL dropped_done: got done=%b busy=%b expected done=0000 busy=1", done, busy);
        end
        n_compared++;
        if (out !== e.val) begin
            n_mismatched++;
            $display("[TB] FAIL dropped_out: got %h expected %h", out, e.val);
        end
        gap();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_contention();
        test_reset_mid_op();
        test_refire_held();
        test_go_dropped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
